fsm_button_turn: RTL and testbench



---
 rtl/fsm_button_turn.sv | 72 +++++++
 tb/tb_fsm_button_turn.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_button_turn.sv
// Move-button FSM for the tic-tac-toe display driver: counts accepted presses,
// tracks whose turn is next, and drives a ready indicator that follows the button.
module fsm_button_turn #(
    parameter int unsigned MAX_MOVES = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       E,
    output logic       z,
    output logic       turn,
    output logic [3:0] moves,
    output logic       board_full
);

    localparam int unsigned MOVES_W = 4;
    localparam logic [MOVES_W-1:0] MAX_MOVES_C = MOVES_W'(MAX_MOVES);

    typedef enum logic [1:0] {
        RELEASED = 2'b00,
        PRESSED  = 2'b01,
        FULL     = 2'b10,
        ILLEGAL  = 2'b11
    } state_e;

    state_e             state_q, state_d;
    logic               turn_q, turn_d;
    logic [MOVES_W-1:0] moves_q, moves_d;

    // State, turn and move-count registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RELEASED;
            turn_q  <= 1'b0;
            moves_q <= '0;
        end else begin
            state_q <= state_d;
            turn_q  <= turn_d;
            moves_q <= moves_d;
        end
    end

    // Next-state logic; a press is counted only on entry from RELEASED
    always_comb begin
        state_d = state_q;
        turn_d  = turn_q;
        moves_d = moves_q;
        case (state_q)
            RELEASED: begin
                if (E) begin
                    if (moves_q < MAX_MOVES_C) begin
                        state_d = PRESSED;
                        moves_d = moves_q + MOVES_W'(1);
                        turn_d  = ~turn_q;
                    end else begin
                        state_d = FULL;
                    end
                end
            end
            PRESSED: begin
                if (!E) state_d = RELEASED;
            end
            FULL:    state_d = FULL;
            default: state_d = RELEASED;
        endcase
    end

    assign z          = reset ? 1'b1 : ~E;
    assign turn       = turn_q;
    assign moves      = moves_q;
    assign board_full = (moves_q == MAX_MOVES_C);

endmodule

// File: tb/tb_fsm_button_turn.sv
// Directed self-checking bench for fsm_button_turn.
module tb_fsm_button_turn;

    logic       clk;
    logic       reset;
    logic       E;
    logic       z;
    logic       turn;
    logic [3:0] moves;
    logic       board_full;

    int checks;
    int errors;

    fsm_button_turn #(.MAX_MOVES(9)) dut (
        .clk       (clk),
        .reset     (reset),
        .E         (E),
        .z         (z),
        .turn      (turn),
        .moves     (moves),
        .board_full(board_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        E     = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        E     = 1'b0;
        #2;
        checks++;
        if (z !== 1'b1 || turn !== 1'b0 || moves !== 4'd0 || board_full !== 1'b0) begin
            errors++;
            $display("FAIL reset_values z=%b turn=%b moves=%0d full=%b expected 1 0 0 0",
                     z, turn, moves, board_full);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (z !== 1'b1 || turn !== 1'b0 || moves !== 4'd0) begin
                errors++;
                $display("FAIL idle_cycle%0d z=%b turn=%b moves=%0d expected 1 0 0",
                         i, z, turn, moves);
            end
        end
    endtask

    task automatic test_press();
        @(negedge clk);
        E = 1'b1;
        #1;
        checks++;
        if (z !== 1'b0 || moves !== 4'd0 || turn !== 1'b0) begin
            errors++;
            $display("FAIL press_comb z=%b moves=%0d turn=%b expected 0 0 0", z, moves, turn);
        end
        @(posedge clk); #1;
        checks++;
        if (moves !== 4'd1 || turn !== 1'b1 || z !== 1'b0) begin
            errors++;
            $display("FAIL press_reg moves=%0d turn=%b z=%b expected 1 1 0", moves, turn, z);
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (moves !== 4'd1 || turn !== 1'b1 || z !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d moves=%0d turn=%b z=%b expected 1 1 0",
                         i, moves, turn, z);
            end
        end
        @(negedge clk);
        E = 1'b0;
        #1;
        checks++;
        if (z !== 1'b1) begin
            errors++;
            $display("FAIL release_z z=%b expected 1", z);
        end
        @(posedge clk); #1;
        checks++;
        if (moves !== 4'd1 || turn !== 1'b1) begin
            errors++;
            $display("FAIL release_reg moves=%0d turn=%b expected 1 1", moves, turn);
        end
    endtask

    task automatic test_alternate();
        logic       exp_z;
        logic [3:0] exp_moves;
        logic       exp_turn;
        do_reset();
        exp_moves = 4'd0;
        exp_turn  = 1'b0;
        for (int p = 0; p < 4; p++) begin
            @(negedge clk);
            E     = (p % 2 == 0);
            exp_z = (p % 2 != 0);
            if (p % 2 == 0) begin
                exp_moves = exp_moves + 4'd1;
                exp_turn  = ~exp_turn;
            end
            #1;
            checks++;
            if (z !== exp_z) begin
                errors++;
                $display("FAIL alt_z level%0d z=%b expected %b", p, z, exp_z);
            end
            repeat (5) @(posedge clk);
            #1;
            checks++;
            if (moves !== exp_moves || turn !== exp_turn || z !== exp_z) begin
                errors++;
                $display("FAIL alt_reg level%0d moves=%0d turn=%b z=%b expected %0d %b %b",
                         p, moves, turn, z, exp_moves, exp_turn, exp_z);
            end
        end
        checks++;
        if (moves !== 4'd2 || turn !== 1'b0) begin
            errors++;
            $display("FAIL alt_final moves=%0d turn=%b expected 2 0", moves, turn);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            E = 1'b1;
            @(negedge clk);
            E = 1'b0;
        end
        @(posedge clk); #1;
        checks++;
        if (moves !== 4'd3 || turn !== 1'b1) begin
            errors++;
            $display("FAIL b2b_one_cycle moves=%0d turn=%b expected 3 1", moves, turn);
        end
    endtask

    task automatic test_full();
        logic [3:0] exp_moves;
        logic       exp_turn;
        logic       exp_full;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            E = 1'b1;
            @(posedge clk); #1;
            exp_moves = 4'(i + 1);
            exp_turn  = ((i + 1) % 2 == 1);
            exp_full  = (i == 8);
            checks++;
            if (moves !== exp_moves || turn !== exp_turn || board_full !== exp_full) begin
                errors++;
                $display("FAIL full_seq%0d moves=%0d turn=%b full=%b expected %0d %b %b",
                         i, moves, turn, board_full, exp_moves, exp_turn, exp_full);
            end
            @(negedge clk);
            E = 1'b0;
        end
        @(negedge clk);
        E = 1'b1;
        #1;
        checks++;
        if (z !== 1'b0) begin
            errors++;
            $display("FAIL full_z_press z=%b expected 0", z);
        end
        @(posedge clk); #1;
        checks++;
        if (moves !== 4'd9 || turn !== 1'b1 || board_full !== 1'b1 || 2'(dut.state_q) !== 2'b10) begin
            errors++;
            $display("FAIL full_tenth moves=%0d turn=%b full=%b state=%b expected 9 1 1 10",
                     moves, turn, board_full, 2'(dut.state_q));
        end
        @(negedge clk);
        E = 1'b0;
        #1;
        checks++;
        if (z !== 1'b1) begin
            errors++;
            $display("FAIL full_z_release z=%b expected 1", z);
        end
        @(negedge clk);
        E = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (moves !== 4'd9 || turn !== 1'b1 || 2'(dut.state_q) !== 2'b10) begin
            errors++;
            $display("FAIL full_sticky moves=%0d turn=%b state=%b expected 9 1 10",
                     moves, turn, 2'(dut.state_q));
        end
        @(negedge clk);
        E = 1'b0;
    endtask

    task automatic test_reset_mid_press();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            E = 1'b1;
            @(negedge clk);
            E = 1'b0;
        end
        @(negedge clk);
        E = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (moves !== 4'd5 || turn !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre moves=%0d turn=%b expected 5 1", moves, turn);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (moves !== 4'd0 || turn !== 1'b0 || z !== 1'b1 || board_full !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async moves=%0d turn=%b z=%b full=%b expected 0 0 1 0",
                     moves, turn, z, board_full);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (z !== 1'b0 || moves !== 4'd0) begin
            errors++;
            $display("FAIL midreset_deassert z=%b moves=%0d expected 0 0", z, moves);
        end
        @(posedge clk); #1;
        checks++;
        if (moves !== 4'd1 || turn !== 1'b1) begin
            errors++;
            $display("FAIL midreset_repress moves=%0d turn=%b expected 1 1", moves, turn);
        end
        @(negedge clk);
        E = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_press();
        test_hold();
        test_alternate();
        test_back_to_back();
        test_full();
        test_reset_mid_press();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
